// File: rtl/sram_responder_pkg.sv
// sram_responder_pkg: shared FSM states, block count, idle output values and counter-width helper for sram_bus_responder
package sram_responder_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK, RECOVER} state_t;
  localparam int NUM_BLOCKS = 4;
  localparam logic [NUM_BLOCKS-1:0] CE_IDLE = 4'hF;
  localparam logic STROBE_OFF = 1'b1;
  function automatic int cnt_width(input int n);
    return n < 2 ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sram_bus_responder_if.sv
// sram_bus_responder_if: 68k strobes/block selects in, SRAM enables and DTACK_L out; slave = responder side, master = bus side
interface sram_bus_responder_if import sram_responder_pkg::*;;
  logic AS_L;
  logic UDS_L;
  logic LDS_L;
  logic RW;
  logic [NUM_BLOCKS-1:0] Block_H;
  logic [NUM_BLOCKS-1:0] SRamCE_L;
  logic SRamOE_L;
  logic SRamWE_L;
  logic SRamUB_L;
  logic SRamLB_L;
  logic DTACK_L;
  modport slave (
    input AS_L, UDS_L, LDS_L, RW, Block_H,
    output SRamCE_L, SRamOE_L, SRamWE_L, SRamUB_L, SRamLB_L, DTACK_L
  );
  modport master (
    output AS_L, UDS_L, LDS_L, RW, Block_H,
    input SRamCE_L, SRamOE_L, SRamWE_L, SRamUB_L, SRamLB_L, DTACK_L
  );
endinterface

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: wait-state down-counter; clk/rst_l (sync, active-low), load (preset WAIT_STATES), dec (count down, stops at 0), zero flag out
module sram_wait_counter import sram_responder_pkg::*; #(
  parameter int WAIT_STATES = 2
) (
  input  logic clk,
  input  logic rst_l,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CW = cnt_width(WAIT_STATES);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_l) cnt <= '0;
    else if (load) cnt <= CW'(WAIT_STATES);
    else if (dec && cnt != '0) cnt <= cnt - CW'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/sram_bus_responder.sv
// sram_bus_responder: 68k SRAM bus responder; Clock, Reset_L (sync, active-low), bus (sram_bus_responder_if.slave); SRAM_WRITE_PROTECT_EN blocks writes to WP_BLOCK
module sram_bus_responder import sram_responder_pkg::*; #(
  parameter int WAIT_STATES = 2,
  parameter int WP_BLOCK = 3
) (
  input logic Clock,
  input logic Reset_L,
  sram_bus_responder_if.slave bus
);
  state_t state, state_d;
  logic [NUM_BLOCKS-1:0] ce_q, ce_d;
  logic oe_q, oe_d, we_q, we_d, ub_q, ub_d, lb_q, lb_d, dt_q, dt_d;
  logic [1:0] idx;
  logic start, wp, zero;
  assign idx = {bus.Block_H[3] | bus.Block_H[2], bus.Block_H[3] | bus.Block_H[1]};
  assign start = !bus.AS_L && $onehot(bus.Block_H) && (!bus.UDS_L || !bus.LDS_L);
`ifdef SRAM_WRITE_PROTECT_EN
  assign wp = idx == WP_BLOCK[1:0];
`else
  logic unused_wp;
  assign unused_wp = ^WP_BLOCK;
  assign wp = 1'b0;
`endif
  sram_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_cnt (
    .clk(Clock),
    .rst_l(Reset_L),
    .load(state == IDLE && start),
    .dec(state == ACCESS),
    .zero(zero)
  );
  always_ff @(posedge Clock)
    if (!Reset_L) begin
      state <= IDLE;
      ce_q <= CE_IDLE;
      {oe_q, we_q, ub_q, lb_q, dt_q} <= {5{STROBE_OFF}};
    end else begin
      state <= state_d;
      ce_q <= ce_d;
      {oe_q, we_q, ub_q, lb_q, dt_q} <= {oe_d, we_d, ub_d, lb_d, dt_d};
    end
  // the registered enables double as the latched RW/strobes/block for the whole cycle
  always_comb begin
    state_d = state;
    ce_d = CE_IDLE;
    {oe_d, we_d, ub_d, lb_d, dt_d} = {5{STROBE_OFF}};
    case (state)
      IDLE:
        if (start) begin
          state_d = ACCESS;
          ce_d = CE_IDLE & ~(NUM_BLOCKS'(1) << idx);
          oe_d = ~bus.RW;
          we_d = bus.RW | wp;
          ub_d = bus.UDS_L;
          lb_d = bus.LDS_L;
        end
      ACCESS:
        if (bus.AS_L) state_d = RECOVER;
        else begin
          state_d = zero ? ACK : ACCESS;
          {ce_d, oe_d, ub_d, lb_d} = {ce_q, oe_q, ub_q, lb_q};
          we_d = zero | we_q;
          dt_d = ~zero;
        end
      ACK:
        if (bus.AS_L) state_d = RECOVER;
        else begin
          {ce_d, oe_d, we_d, ub_d, lb_d} = {ce_q, oe_q, we_q, ub_q, lb_q};
          dt_d = 1'b0;
        end
      RECOVER: state_d = IDLE;
    endcase
  end
  assign bus.SRamCE_L = ce_q;
  assign bus.SRamOE_L = oe_q;
  assign bus.SRamWE_L = we_q;
  assign bus.SRamUB_L = ub_q;
  assign bus.SRamLB_L = lb_q;
  assign bus.DTACK_L = dt_q;
endmodule

// File: tb/tb_sram_bus_responder.sv
// tb_sram_bus_responder: vector table, corner sequences and randomized model check for WAIT_STATES=2 and WAIT_STATES=0 responders
module tb_sram_bus_responder;
  import sram_responder_pkg::*;
  localparam logic [8:0] IDLE_O = 9'b1111_11111;
`ifdef SRAM_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;
  sram_bus_responder_if bus_a ();
  sram_bus_responder_if bus_b ();
  sram_bus_responder #(.WAIT_STATES(2), .WP_BLOCK(3)) dut_a (.Clock(clk), .Reset_L(rst_l), .bus(bus_a));
  sram_bus_responder #(.WAIT_STATES(0), .WP_BLOCK(3)) dut_b (.Clock(clk), .Reset_L(rst_l), .bus(bus_b));
  int n_cmp = 0;
  int n_bad = 0;
  bit model_on = 1'b0;
  int ws[2] = '{2, 0};
  bit m_act[2], m_rec[2], m_rw[2], m_uds[2], m_lds[2];
  int m_age[2], m_idx[2];
  typedef struct {
    bit rst, as, uds, lds, rw;
    logic [3:0] blk;
    logic [8:0] exp;
  } vec_t;
  vec_t tv[17];
  function automatic logic [8:0] outs(int d);
    return d == 0 ? {bus_a.SRamCE_L, bus_a.SRamOE_L, bus_a.SRamWE_L, bus_a.SRamUB_L, bus_a.SRamLB_L, bus_a.DTACK_L}
                  : {bus_b.SRamCE_L, bus_b.SRamOE_L, bus_b.SRamWE_L, bus_b.SRamUB_L, bus_b.SRamLB_L, bus_b.DTACK_L};
  endfunction
  task automatic chk(string name, logic [8:0] got, logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got ce/oe/we/ub/lb/dtack=%b required %b", name, $time, got, exp);
    end
  endtask
  // cycle-level reference: a bus cycle is "active" from its start edge, acknowledged once
  // more than WAIT_STATES edges have passed, and followed by one idle recovery edge
  task automatic model_edge(int d, bit rst, bit as, bit uds, bit lds, bit rw, logic [3:0] blk);
    bit st;
    st = !as && $countones(blk) == 1 && (!uds || !lds);
    if (!rst) begin
      m_act[d] = 0;
      m_rec[d] = 0;
    end else if (m_rec[d]) m_rec[d] = 0;
    else if (m_act[d]) begin
      if (as) begin
        m_act[d] = 0;
        m_rec[d] = 1;
      end else m_age[d]++;
    end else if (st) begin
      m_act[d] = 1;
      m_age[d] = 0;
      m_idx[d] = $clog2(blk);
      m_rw[d] = rw;
      m_uds[d] = uds;
      m_lds[d] = lds;
    end
  endtask
  function automatic logic [8:0] m_exp(int d);
    bit acked, wp;
    logic [3:0] ce;
    if (!m_act[d]) return IDLE_O;
    acked = m_age[d] > ws[d];
    wp = WP_EN && m_idx[d] == 3 && !m_rw[d];
    ce = 4'hF;
    ce[m_idx[d]] = 1'b0;
    return {ce, !m_rw[d], m_rw[d] | wp | acked, m_uds[d], m_lds[d], !acked};
  endfunction
  task automatic step(bit rst, bit as, bit uds, bit lds, bit rw, logic [3:0] blk);
    rst_l = rst;
    bus_a.AS_L = as; bus_a.UDS_L = uds; bus_a.LDS_L = lds; bus_a.RW = rw; bus_a.Block_H = blk;
    bus_b.AS_L = as; bus_b.UDS_L = uds; bus_b.LDS_L = lds; bus_b.RW = rw; bus_b.Block_H = blk;
    if (model_on) for (int d = 0; d < 2; d++) model_edge(d, rst, as, uds, lds, rw, blk);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [8:0] rd, rda, wp_o;
    bit as;
    rd = 9'b1011_01001;
    rda = 9'b1011_01000;
    tv[0] = '{0, 0, 0, 0, 1, 4'b0100, IDLE_O};
    tv[1] = '{0, 0, 0, 0, 1, 4'b0100, IDLE_O};
    tv[2] = '{1, 0, 0, 0, 1, 4'b0100, rd};
    tv[3] = '{1, 0, 0, 0, 1, 4'b0100, rd};
    tv[4] = '{1, 0, 0, 0, 1, 4'b0100, rd};
    tv[5] = '{1, 0, 0, 0, 1, 4'b0100, rda};
    tv[6] = '{1, 0, 0, 0, 1, 4'b0100, rda};
    tv[7] = '{1, 1, 0, 0, 1, 4'b0100, IDLE_O};
    tv[8] = '{1, 0, 0, 0, 1, 4'b0100, IDLE_O};
    tv[9] = '{1, 0, 0, 0, 1, 4'b0100, rd};
    tv[10] = '{1, 0, 0, 0, 1, 4'b0100, rd};
    tv[11] = '{1, 1, 0, 0, 1, 4'b0100, IDLE_O};
    tv[12] = '{1, 1, 0, 0, 1, 4'b0100, IDLE_O};
    tv[13] = '{1, 1, 0, 0, 1, 4'b0100, IDLE_O};
    tv[14] = '{1, 0, 0, 0, 1, 4'b0100, rd};
    tv[15] = '{0, 0, 0, 0, 1, 4'b0100, IDLE_O};
    tv[16] = '{1, 1, 0, 0, 1, 4'b0100, IDLE_O};
    for (int i = 0; i < 17; i++) begin
      step(tv[i].rst, tv[i].as, tv[i].uds, tv[i].lds, tv[i].rw, tv[i].blk);
      chk($sformatf("table[%0d]", i), outs(0), tv[i].exp);
    end
    step(0, 1, 1, 1, 1, 4'b0000);
    step(1, 0, 1, 0, 0, 4'b0010);
    chk("wr_b1_start", outs(1), 9'b1101_10101);
    step(1, 0, 1, 0, 0, 4'b0010);
    chk("wr_b1_ack", outs(1), 9'b1101_11100);
    step(1, 1, 1, 0, 0, 4'b0010);
    chk("wr_b1_recover", outs(1), IDLE_O);
    step(1, 1, 1, 1, 1, 4'b0000);
    wp_o = {4'b0111, 1'b1, WP_EN, 3'b001};
    step(1, 0, 0, 0, 0, 4'b1000);
    chk("wr_b3_start", outs(1), wp_o);
    step(1, 0, 0, 0, 0, 4'b1000);
    chk("wr_b3_ack", outs(1), 9'b0111_11000);
    step(1, 1, 0, 0, 0, 4'b1000);
    step(1, 1, 0, 0, 0, 4'b1000);
    step(1, 0, 0, 0, 0, 4'b0001);
    chk("wr_b0_start", outs(1), 9'b1110_10001);
    step(1, 0, 0, 0, 0, 4'b0001);
    chk("wr_b0_ack", outs(1), 9'b1110_11000);
    step(0, 1, 1, 1, 1, 4'b0000);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 0, 1, i < 20 ? 4'b0000 : 4'b0011);
      chk("illegal_a", outs(0), IDLE_O);
      chk("illegal_b", outs(1), IDLE_O);
    end
    model_on = 1'b1;
    step(0, 1, 1, 1, 1, 4'b0000);
    as = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] blk;
      if ($urandom_range(0, 99) < 20) as = ~as;
      blk = $urandom_range(0, 99) < 75 ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      step($urandom_range(0, 99) != 0, as, 1'($urandom), 1'($urandom), 1'($urandom), blk);
      chk("rand_a", outs(0), m_exp(0));
      chk("rand_b", outs(1), m_exp(1));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
